// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by the controller top and its hazard comparator.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } mem_state_t;

  localparam int unsigned WAIT_W = 10;

  // Control values a bubbled MEM/WB register loads in place of the real ones
  localparam logic NOP_REGWRITE = 1'b0;
  localparam logic NOP_MEMTOREG = 1'b0;

  function automatic logic is_mem_op(logic rd, logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard.sv
// Load-use hazard compare between the EX-stage load and ID-stage sources.
// Purely combinational; x0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memread,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  logic rd_nz;
  logic src_hit;

  assign rd_nz   = |rd;
  assign src_hit = (rd == rs1) | (rd == rs2);
  assign hazard  = memread & rd_nz & src_hit;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: data-memory handshake FSM with watchdog,
// load-use bubbles, branch flush and a saturating stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_mem_memread_i,
  input  logic             ex_mem_memwrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic [4:0]       if_id_rs1_i,
  input  logic [4:0]       if_id_rs2_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_hold_o,
  output logic             mem_wb_bubble_o,
  output logic             err_o,
  input  logic             stat_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memop;
  logic              hold;
  logic              timeout;
  logic              hz;
  logic              lu;

  assign memop = is_mem_op(ex_mem_memread_i, ex_mem_memwrite_i);

  hazard_detect u_hazard (
    .memread (id_ex_memread_i),
    .rd      (id_ex_rd_i),
    .rs1     (if_id_rs1_i),
    .rs2     (if_id_rs2_i),
    .hazard  (hz)
  );

  always_comb begin
    hold       = 1'b0;
    dmem_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        dmem_req_o = memop;
        hold       = memop & ~dmem_ack_i;
      end
      WAIT: begin
        dmem_req_o = 1'b1;
        hold       = ~dmem_ack_i;
      end
      default: begin
        dmem_req_o = 1'b0;
        hold       = 1'b0;
      end
    endcase
  end

  assign timeout = (state == WAIT) & ~dmem_ack_i & (wait_cnt == LAST);
  assign lu      = hz & ~hold;

  assign pc_write_o      = ~(hold | lu);
  assign if_id_write_o   = ~(hold | lu);
  assign id_ex_bubble_o  = lu;
  assign if_id_flush_o   = branch_taken_i & ~hold & ~lu;
  assign ex_mem_hold_o   = hold;
  // An abort squashes the load's writeback, so it bubbles like a hold
  assign mem_wb_bubble_o = hold | (state == ABORT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop & ~dmem_ack_i) begin
            state    <= WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= ABORT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (stat_clr_i) begin
        err_o       <= 1'b0;
        stall_cnt_o <= '0;
      end else begin
        if (timeout)
          err_o <= 1'b1;
        if (!pc_write_o && stall_cnt_o != '1)
          stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with TIMEOUT=4.
// Inputs change on negedge; outputs sampled 1 ns later.
module tb_pipe_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_mem_memread_i;
  logic        ex_mem_memwrite_i;
  logic        dmem_ack_i;
  logic        dmem_req_o;
  logic        id_ex_memread_i;
  logic [4:0]  id_ex_rd_i;
  logic [4:0]  if_id_rs1_i;
  logic [4:0]  if_id_rs2_i;
  logic        branch_taken_i;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_bubble_o;
  logic        ex_mem_hold_o;
  logic        mem_wb_bubble_o;
  logic        err_o;
  logic        stat_clr_i;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_stall_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (16)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ex_mem_memread_i  (ex_mem_memread_i),
    .ex_mem_memwrite_i (ex_mem_memwrite_i),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_req_o        (dmem_req_o),
    .id_ex_memread_i   (id_ex_memread_i),
    .id_ex_rd_i        (id_ex_rd_i),
    .if_id_rs1_i       (if_id_rs1_i),
    .if_id_rs2_i       (if_id_rs2_i),
    .branch_taken_i    (branch_taken_i),
    .pc_write_o        (pc_write_o),
    .if_id_write_o     (if_id_write_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .ex_mem_hold_o     (ex_mem_hold_o),
    .mem_wb_bubble_o   (mem_wb_bubble_o),
    .err_o             (err_o),
    .stat_clr_i        (stat_clr_i),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic quiet();
    ex_mem_memread_i  = 1'b0;
    ex_mem_memwrite_i = 1'b0;
    dmem_ack_i        = 1'b0;
    id_ex_memread_i   = 1'b0;
    id_ex_rd_i        = 5'd0;
    if_id_rs1_i       = 5'd0;
    if_id_rs2_i       = 5'd0;
    branch_taken_i    = 1'b0;
    stat_clr_i        = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lu_set(input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2);
    id_ex_memread_i = mr;
    id_ex_rd_i      = rd;
    if_id_rs1_i     = r1;
    if_id_rs2_i     = r2;
  endtask

  initial begin
    quiet();
    rst_i = 1'b0;
    #12;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    chk("rst_pcw", pc_write_o, 1);
    chk("rst_ifw", if_id_write_o, 1);
    chk("rst_hold", ex_mem_hold_o, 0);
    chk("rst_mwb", mem_wb_bubble_o, 0);
    chk("rst_flush", if_id_flush_o, 0);
    nxt(); rst_i = 1'b1;

    // zero-wait load
    nxt(); ex_mem_memread_i = 1; dmem_ack_i = 1; settle();
    chk("zw_req", dmem_req_o, 1);
    chk("zw_pcw", pc_write_o, 1);
    chk("zw_hold", ex_mem_hold_o, 0);
    nxt(); quiet(); settle();
    chk("zw_req_off", dmem_req_o, 0);
    chk("zw_cnt", stall_cnt_o, 0);

    // ack three cycles after first request
    nxt(); ex_mem_memread_i = 1; settle();
    chk("w3_hold0", ex_mem_hold_o, 1);
    chk("w3_mwb0", mem_wb_bubble_o, 1);
    chk("w3_pcw0", pc_write_o, 0);
    nxt(); ex_mem_memread_i = 0; settle();
    chk("w3_req1", dmem_req_o, 1);
    chk("w3_hold1", ex_mem_hold_o, 1);
    nxt(); settle();
    chk("w3_hold2", ex_mem_hold_o, 1);
    nxt(); dmem_ack_i = 1; settle();
    chk("w3_hold_ack", ex_mem_hold_o, 0);
    chk("w3_mwb_ack", mem_wb_bubble_o, 0);
    chk("w3_pcw_ack", pc_write_o, 1);
    chk("w3_req_ack", dmem_req_o, 1);
    nxt(); quiet(); settle();
    chk("w3_req_done", dmem_req_o, 0);
    chk("w3_cnt", stall_cnt_o, 3);
    nxt(); stat_clr_i = 1;
    nxt(); stat_clr_i = 0; settle();
    chk("clr_cnt", stall_cnt_o, 0);

    // watchdog abort
    nxt(); ex_mem_memwrite_i = 1; settle();
    chk("to_hold0", ex_mem_hold_o, 1);
    nxt(); ex_mem_memwrite_i = 0; settle();
    chk("to_hold1", ex_mem_hold_o, 1);
    nxt(); settle();
    chk("to_hold2", ex_mem_hold_o, 1);
    chk("to_err_pre", err_o, 0);
    nxt(); branch_taken_i = 1; settle();
    chk("to_hold3", ex_mem_hold_o, 1);
    chk("to_flush_held", if_id_flush_o, 0);
    nxt(); settle();
    chk("ab_req", dmem_req_o, 0);
    chk("ab_hold", ex_mem_hold_o, 0);
    chk("ab_mwb", mem_wb_bubble_o, 1);
    chk("ab_pcw", pc_write_o, 1);
    chk("ab_err", err_o, 1);
    chk("ab_flush", if_id_flush_o, 1);
    nxt(); branch_taken_i = 0; settle();
    chk("ab_done_mwb", mem_wb_bubble_o, 0);
    chk("ab_err_stick", err_o, 1);
    chk("ab_cnt", stall_cnt_o, 4);
    nxt(); stat_clr_i = 1;
    nxt(); stat_clr_i = 0; settle();
    chk("clr_err", err_o, 0);
    chk("clr_cnt2", stall_cnt_o, 0);

    // load-use: lw x5 then add x6,x5,x1, with a taken branch
    nxt(); lu_set(1, 5, 5, 1); branch_taken_i = 1; settle();
    chk("lu_pcw", pc_write_o, 0);
    chk("lu_ifw", if_id_write_o, 0);
    chk("lu_bub", id_ex_bubble_o, 1);
    chk("lu_flush", if_id_flush_o, 0);
    nxt(); lu_set(0, 0, 5, 1); settle();
    chk("lu_after_pcw", pc_write_o, 1);
    chk("br_flush", if_id_flush_o, 1);
    nxt(); branch_taken_i = 0; lu_set(1, 0, 0, 1); settle();
    chk("lu_x0_pcw", pc_write_o, 1);
    chk("lu_x0_bub", id_ex_bubble_o, 0);
    nxt(); lu_set(1, 7, 3, 7); settle();
    chk("lu_rs2_bub", id_ex_bubble_o, 1);
    nxt(); lu_set(0, 7, 7, 7); settle();
    chk("lu_nold_pcw", pc_write_o, 1);
    chk("lu_cnt", stall_cnt_o, 2);

    // memory hold outranks load-use
    nxt(); lu_set(1, 9, 9, 0); ex_mem_memread_i = 1; settle();
    chk("pri_hold", ex_mem_hold_o, 1);
    chk("pri_bub", id_ex_bubble_o, 0);
    nxt(); ex_mem_memread_i = 0; dmem_ack_i = 1; settle();
    chk("pri_rel_bub", id_ex_bubble_o, 1);
    nxt(); quiet();

    // asynchronous reset during WAIT
    nxt(); ex_mem_memread_i = 1;
    nxt(); ex_mem_memread_i = 0; settle();
    chk("ar_req_wait", dmem_req_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_req_drop", dmem_req_o, 0);
    chk("ar_hold_drop", ex_mem_hold_o, 0);
    chk("ar_cnt", stall_cnt_o, 0);
    nxt(); rst_i = 1'b1; settle();
    chk("ar_idle_req", dmem_req_o, 0);

    // saturation of the stall counter
    nxt(); lu_set(1, 3, 3, 0);
    repeat (65533) @(posedge clk_i);
    #1;
    chk("sat_near", stall_cnt_o, 16'hFFFD);
    repeat (5) @(posedge clk_i);
    #1;
    chk("sat_top", stall_cnt_o, 16'hFFFF);
    nxt(); stat_clr_i = 1;
    @(posedge clk_i); #1;
    chk("clr_over_inc", stall_cnt_o, 0);
    nxt(); quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Sequences variable-latency data-memory accesses with a req/ack handshake and a watchdog timeout.
- Detects load-use hazards and squashes wrong-path fetches on taken branches.
- Drives the write-enable, bubble and flush controls of every pipeline register, and keeps a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 64, WAIT cycles without ack before the access is aborted (range 2..1023).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- ex_mem_memread_i  in  1  load in the MEM stage.
- ex_mem_memwrite_i  in  1  store in the MEM stage.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- dmem_req_o  out  1  data memory request.
- id_ex_memread_i  in  1  load in the EX stage.
- id_ex_rd_i  in  5  destination of the EX-stage instruction.
- if_id_rs1_i  in  5  source 1 of the ID-stage instruction.
- if_id_rs2_i  in  5  source 2 of the ID-stage instruction.
- branch_taken_i  in  1  branch resolved taken in ID.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID load enable.
- if_id_flush_o  out  1  IF/ID clear to NOP.
- id_ex_bubble_o  out  1  ID/EX load with zero controls.
- ex_mem_hold_o  out  1  ID/EX and EX/MEM hold their current contents.
- mem_wb_bubble_o  out  1  MEM/WB loads RegWrite=0, MemToReg=0.
- err_o  out  1  sticky memory-timeout flag.
- stat_clr_i  in  1  synchronous clear of stall_cnt_o and err_o.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o=0.

Behaviour:
- Reset is asynchronous and active-low on rst_i; clock is clk_i.
- Reset values: state=IDLE, dmem_req_o=0, err_o=0, stall_cnt_o=0, wait counter=0. Outputs are combinational from state and inputs, so after reset they evaluate to pc_write_o=1, if_id_write_o=1 and all hold/bubble/flush outputs 0 when no hazard is present.
- Reset mid-access: the FSM returns to IDLE at once and dmem_req_o drops without waiting for ack.
- memop = ex_mem_memread_i | ex_mem_memwrite_i.
- States: IDLE, WAIT, ABORT (2-bit encoding).
- IDLE:
  - dmem_req_o = memop.
  - memop & ack: zero-wait access. No hold, pipeline advances, no stall cycle.
  - memop & !ack: memory hold this cycle; next state WAIT; wait counter = 1.
- WAIT:
  - dmem_req_o=1; memory hold.
  - ack: hold released this cycle, MEM/WB samples dmem data directly, next state IDLE.
  - No ack and counter = TIMEOUT-1: next state ABORT, err_o set.
  - Otherwise counter increments.
  - memop is not re-sampled in WAIT.
- ABORT (exactly one cycle):
  - dmem_req_o=0; no hold; mem_wb_bubble_o=1, which squashes the aborted load's writeback; pipeline advances.
  - Next state IDLE.
- Memory hold asserts: pc_write_o=0, if_id_write_o=0, ex_mem_hold_o=1, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0.
- Load-use hazard, evaluated only when there is no memory hold:
  - Condition: id_ex_memread_i & id_ex_rd_i!=0 & (id_ex_rd_i==if_id_rs1_i | id_ex_rd_i==if_id_rs2_i).
  - Action: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1.
- Branch flush: if_id_flush_o = branch_taken_i & !memory hold & !load-use.
- Priority: memory hold > load-use > branch flush.
- stall_cnt_o increments on every cycle with pc_write_o=0 and saturates at all-ones.
- stat_clr_i has priority over increment and over setting err_o in the same cycle.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (IDLE/WAIT/ABORT) and the NOP-control constant zero values used by the bubble logic.
- One sub-module, hazard_detect: purely combinational load-use compare, instantiated once.
- FSM, wait counter and stall counter stay in the top module.

Test Plan:
- Load with ack in the same cycle as req -> dmem_req_o=1 for one cycle, pc_write_o stays 1, stall_cnt_o unchanged.
- Load with ack 3 cycles after first req -> ex_mem_hold_o=1 and mem_wb_bubble_o=1 for 3 cycles, released on the ack cycle; stall_cnt_o=3.
- TIMEOUT=4, ack never arrives -> 4 hold cycles, then an ABORT cycle with req=0 and mem_wb_bubble_o=1; err_o=1 until stat_clr_i.
- Load x5 in EX followed by ADD x6,x5,x1 in ID -> one cycle with pc_write_o=0 and id_ex_bubble_o=1. Repeat with rd=x0 -> no stall.
- branch_taken_i during a memory WAIT -> if_id_flush_o=0 until the hold releases. branch_taken_i together with load-use -> no flush, bubble only.
- rst_i low during WAIT -> dmem_req_o drops asynchronously. Separately: preload stall_cnt_o near all-ones, stall 5 cycles -> saturates at 0xFFFF.
